// File: rtl/arb_mux_nbit_if.sv
// Handshake bundle for arb_mux_nbit: CH producer channels in, one
// registered consumer channel out.
//   in_data   CH*n  flattened channel data, channel i at [i*n +: n]
//   in_valid  CH    per-channel valid
//   in_ready  CH    per-channel ready, at most one bit set
//   mode      1     0 = fixed priority, 1 = round-robin
//   out_data  n     registered selected word
//   out_ch    CW    channel that supplied out_data
//   out_valid 1     output register holds a word
//   out_ready 1     consumer accepts out_data this cycle
// The slave modport is the arbiter's view; master is the
// producer/consumer environment's view.
interface arb_mux_nbit_if #(
    parameter int n  = 4,
    parameter int CH = 4
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic [CH*n-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [n-1:0]    out_data;
    logic [CW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_data,
        output in_valid,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid
    );
endinterface

// File: rtl/arb_mux_nbit.sv
// CH-way n-bit arbitrating mux with a registered valid/ready output.
// Ports: clk, rst_n (async active-low), bus (arb_mux_nbit_if.slave).
module arb_mux_nbit #(
    parameter int n  = 4,
    parameter int CH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_mux_nbit_if.slave bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic [n-1:0]  out_data_q;
    logic [n-1:0]  out_data_d;
    logic [CW-1:0] out_ch_q;
    logic [CW-1:0] out_ch_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;

    logic          load;
    logic          in_xfer;
    logic          out_xfer;

    logic          fp_vld;
    logic [CW-1:0] fp_idx;
    logic          rr_vld;
    logic [CW-1:0] rr_idx;
    logic          gnt_vld;
    logic [CW-1:0] gnt_idx;
    logic [n-1:0]  sel_data;
    logic [CH-1:0] rdy;

    // Output register can accept a word when empty or draining.
    assign load     = !out_valid_q || bus.out_ready;
    assign out_xfer = out_valid_q && bus.out_ready;

    // Fixed priority: descending scan so the lowest valid index
    // is the last one written.
    always_comb begin
        fp_vld = 1'b0;
        fp_idx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                fp_vld = 1'b1;
                fp_idx = CW'(i);
            end
        end
    end

    // Round-robin: same descending trick over offsets from ptr,
    // so the smallest offset (closest to ptr) wins.
    always_comb begin : rr_search
        int k;
        rr_vld = 1'b0;
        rr_idx = '0;
        k      = 0;
        for (int j = CH - 1; j >= 0; j--) begin
            k = int'(ptr_q) + j;
            if (k >= CH) begin
                k = k - CH;
            end
            if (bus.in_valid[k]) begin
                rr_vld = 1'b1;
                rr_idx = CW'(k);
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (bus.mode) begin
            gnt_vld = rr_vld;
            gnt_idx = rr_idx;
        end else begin
            gnt_vld = fp_vld;
            gnt_idx = fp_idx;
        end
    end

    // rst_n gates the ready so nothing is offered while in reset,
    // even though load is already true with out_valid cleared.
    assign in_xfer  = rst_n && load && gnt_vld;
    assign sel_data = bus.in_data[int'(gnt_idx)*n +: n];

    always_comb begin
        rdy = '0;
        for (int i = 0; i < CH; i++) begin
            rdy[i] = in_xfer && (gnt_idx == CW'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (in_xfer) begin
            out_data_d  = sel_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (gnt_idx == CW'(CH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/arb_mux_nbit.md
Name: arb_mux_nbit

Overview:
- Parametrised successor to the team's n-bit combinational 4:1 mux.
- Selects one of CH n-bit input channels and forwards it through a registered output stage with valid/ready handshakes.
- Internal arbitration replaces the external select: fixed-priority or round-robin, chosen at run time.
- Sits between several producer blocks and one shared consumer; one word transfers per cycle at full throughput.

Parameters:
- n, 4, data width per channel in bits.
- CH, 4, number of input channels, ≥2. The index width is CW = $clog2(CH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CH*n  flattened channel data; channel i occupies bits [i*n +: n].
- in_valid  input  CH  per-channel valid.
- in_ready  output  CH  per-channel ready; at most one bit set.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- out_data  output  n  registered selected data.
- out_ch  output  CW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset: asynchronous on rst_n low; out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0. All in_ready bits are 0 while rst_n is low.
- Releasing rst_n takes effect at the next rising edge; state is not cleared further after release.
- load = !out_valid || out_ready. This combinational term means the output register can take a new word this cycle.
- Grant, combinational from in_valid, mode and ptr:
  - mode=0: lowest index i with in_valid[i]=1.
  - mode=1: first index with in_valid set, searching ptr, ptr+1, … CH-1, 0, … ptr-1 (wrap modulo CH).
  - No valid input: no grant.
- in_ready[i] = load && grant[i]. A channel is never readied unless it is asserting valid.
- Input transfer on channel k occurs when in_valid[k] && in_ready[k]. On that edge:
  - out_data <= channel k data;
  - out_ch <= k;
  - out_valid <= 1.
- Output transfer occurs when out_valid && out_ready. If there is no simultaneous input transfer, out_valid <= 0; out_data and out_ch hold their last values.
- Simultaneous output and input transfer: the register is replaced in the same cycle. Sustained throughput is 1 word/cycle.
- Latency: 1 cycle from input transfer to out_valid/out_data visible.
- Backpressure (out_valid=1, out_ready=0):
  - out_data, out_ch and out_valid stay stable;
  - all in_ready are 0;
  - ptr does not change.
- Pointer update: on every input transfer from channel k, ptr <= (k==CH-1) ? 0 : k+1. This update happens in both modes. ptr changes only on input transfers.
- Mode switch: sampled combinationally each cycle and affects the current cycle's grant. ptr is preserved across switches. An in-flight output word is unaffected.
- Inputs whose in_valid drops before being granted are simply not selected; no state is kept per channel.
- Reset mid-operation: a pending output word is discarded (out_valid=0) and ptr returns to 0. Producers must re-present their data.
- Combinational paths: in_valid → in_ready and out_ready → in_ready. out_data, out_ch and out_valid are pure register outputs.

Test Plan (n=4, CH=4):
1. Reset mid-operation:
   - Stimulus: out_valid=1 holding 4'd7; assert rst_n=0 between clock edges.
   - Required: out_valid=0, out_data=0, out_ch=0 immediately, without waiting for a clock edge.
   - After release with mode=1 and ch1..ch3 valid: first grant goes to ch1.
2. Fixed priority, one-shot producers:
   - Stimulus: mode=0, out_ready=1; channels i hold data i+4 (4'd4..4'd7); each channel drops valid after its transfer.
   - Required: out_ch sequence 0,1,2,3 on consecutive cycles, out_data 4,5,6,7; first out_valid one cycle after the first transfer.
3. Round-robin fairness:
   - Stimulus: mode=1, all four in_valid held high, out_ready=1 for 8 cycles.
   - Required: out_ch = 0,1,2,3,0,1,2,3 with out_valid continuously high.
   - Same stimulus with mode=0: out_ch = 0 every cycle.
4. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles with all channels valid.
   - Required: after the first load, out_data/out_ch are frozen, in_ready=4'b0000 and ptr is unchanged.
   - Then out_ready=1: one transfer per cycle resumes, continuing round-robin from the frozen ptr.
5. Pointer wrap:
   - Stimulus: mode=1, ptr=3 (after a ch2 transfer), only ch1 valid.
   - Required: grant ch1 (search 3→0→1); after the transfer ptr=2.
   - A following ch3 transfer sets ptr=0.
6. Idle/empty:
   - Stimulus: no in_valid; drain the last word with out_ready=1.
   - Required: out_valid falls to 0; out_data and out_ch hold their last values; in_ready stays 0.
